fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port jump_en_i  in  1  redirect request from execute (branch/jump taken).
REQ-005 SHALL have port jump_addr_i  in  64  redirect target.
REQ-006 SHALL have port id_ready_i  in  1  if_id accepts instruction this cycle.
REQ-007 SHALL have port inst_valid_o  out  1  inst_o/inst_addr_o valid to if_id.
REQ-008 SHALL have port inst_addr_o  out  64  PC of presented instruction.
REQ-009 SHALL have port inst_o  out  32  presented instruction.
REQ-010 SHALL have port mem_req_o  out  1  fetch request to instruction memory.
REQ-011 SHALL have port mem_addr_o  out  64  request address, 8-byte aligned (bits [2:0]=0).
REQ-012 SHALL have port mem_gnt_i  in  1  request accepted this cycle.
REQ-013 SHALL have port mem_rvalid_i  in  1  read data valid; exactly one per grant, earliest the cycle after grant.
REQ-014 SHALL have port mem_rdata_i  in  64  read doubleword.

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT, KILL, HOLD; at most one outstanding memory request.
REQ-016 SHALL hold a fetch PC register pc_q; mem_addr_o = {req_pc[63:3],3'b000}, where req_pc is latched on entering REQ.
REQ-017 SHALL keep mem_req_o and mem_addr_o stable in REQ until mem_gnt_i; mem_req_o=1 only in REQ.
REQ-018 IDLE -> REQ unconditionally (first cycle after reset release).
REQ-019 REQ: gnt -> WAIT; gnt with redirect pending or jump_en_i -> KILL.
REQ-020 WAIT: rvalid -> HOLD, latching inst = req_pc[2] ? rdata[63:32] : rdata[31:0] and inst_addr = req_pc.
REQ-021 WAIT: jump_en_i -> KILL (in-flight response discarded); jump_en_i with rvalid same cycle -> REQ at jump_addr_i, data dropped.
REQ-022 KILL: rvalid -> REQ at pc_q; no instruction presented from killed response.
REQ-023 HOLD: inst_valid_o = 1 & ~jump_en_i; id_ready_i without jump -> pc_q <= pc_q+4, REQ.
REQ-024 jump_en_i in any state SHALL set pc_q <= jump_addr_i; redirect has priority over id_ready_i (held instruction not transferred).
REQ-025 Redirect in REQ without gnt SHALL set a pending-kill flag, cleared on entering KILL.
REQ-026 pc_q+4 SHALL wrap modulo 2^64; jump_addr_i[1:0] ignored (treated as 0).
REQ-027 Latency: gnt at cycle N, rvalid at N+1 -> inst_valid_o at N+2.
REQ-028 inst_o/inst_addr_o SHALL stay stable while inst_valid_o=1 and not accepted.

Reset
REQ-029 On rst_n=0 (asynchronous): state=IDLE, pc_q=RESET_PC, pending-kill=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, mem_req_o=0, mem_addr_o=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it; a late rvalid after reset release, before first grant, SHALL be ignored.

Configuration
REQ-031 With FETCH_PERF_EN defined: outputs perf_fetch_cnt_o[63:0] (+1 per accepted instruction) and perf_stall_cnt_o[63:0] (+1 per cycle inst_valid_o=1 & ~id_ready_i), both reset to 0, wrap at 2^64.
REQ-032 Without FETCH_PERF_EN: those ports and counters absent; all other behaviour identical.

Structure
REQ-033 State encodings and RESET_PC default SHALL live in the shared defines header; no local magic numbers.
REQ-034 Perf counters SHALL be sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_EN.

Verification
REQ-035 Reset release, gnt immediate, rvalid+1, id_ready=1 -> mem_addr 0x80000000, then 0x80000000 (pc 0x80000004, inst=rdata[63:32]), then 0x80000008.
REQ-036 id_ready=0 for 5 cycles in HOLD -> inst_valid_o/inst_o stable 5 cycles, no new mem_req_o; perf_stall_cnt_o=5 (FETCH_PERF_EN).
REQ-037 jump_en_i to 0x80001000 during WAIT -> KILL, response dropped, next mem_addr 0x80001000, no valid for killed PC.
REQ-038 jump_en_i while REQ ungranted for 3 cycles -> mem_addr unchanged until gnt, then KILL, then request 0x80001000.
REQ-039 jump_en_i and id_ready_i same HOLD cycle -> inst_valid_o=0, no transfer, next fetch at jump target.
REQ-040 rst_n pulsed low during WAIT -> all outputs reset immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encodings, reset PC, alignment masks.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        KILL = 3'd3,
        HOLD = 3'd4
    } fetch_state_t;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 64'd4;
    localparam logic [XLEN-1:0] INST_ALIGN_MASK  = ~64'h3;
    localparam logic [XLEN-1:0] DWORD_ALIGN_MASK = ~64'h7;

    // Memory returns a doubleword; PC bit 2 selects which half holds the instruction.
    function automatic logic [ILEN-1:0] pick_inst(input logic [XLEN-1:0] dword, input logic upper);
        return upper ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: accepted instructions and stalled presentation cycles, wrapping at 2^64.
// Latency: count visible the cycle after the event.
// Backpressure: none, pure observer.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_stall_cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (fetch_inc) perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
            if (stall_inc) perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller, one outstanding doubleword request; FETCH_PERF_EN adds perf counters.
// Latency: grant at N, rvalid at N+1 -> inst_valid_o at N+2.
// Backpressure: holds the instruction stable until id_ready_i; redirects discard held/in-flight data.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            id_ready_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [ILEN-1:0] inst_o,
`ifdef FETCH_PERF_EN
    output logic [63:0]     perf_fetch_cnt_o,
    output logic [63:0]     perf_stall_cnt_o,
`endif
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            kill_pend_q, kill_pend_d;
    logic            enter_req;
    logic            load_inst;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_pend_d = kill_pend_q;
        enter_req   = 1'b0;
        load_inst   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d   = REQ;
                enter_req = 1'b1;
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (kill_pend_q || jump_en_i) begin
                        state_d     = KILL;
                        kill_pend_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (jump_en_i) begin
                    // Request must stay stable until granted; remember to drop its response.
                    kill_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (jump_en_i && mem_rvalid_i) begin
                    state_d   = REQ;
                    enter_req = 1'b1;
                end else if (jump_en_i) begin
                    state_d = KILL;
                end else if (mem_rvalid_i) begin
                    state_d   = HOLD;
                    load_inst = 1'b1;
                end
            end
            KILL: begin
                if (mem_rvalid_i) begin
                    state_d   = REQ;
                    enter_req = 1'b1;
                end
            end
            HOLD: begin
                if (jump_en_i) begin
                    state_d   = REQ;
                    enter_req = 1'b1;
                end else if (id_ready_i) begin
                    pc_d      = pc_q + PC_STEP;
                    state_d   = REQ;
                    enter_req = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jump_en_i) pc_d = jump_addr_i & INST_ALIGN_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            kill_pend_q <= 1'b0;
            inst_o      <= '0;
            inst_addr_o <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_pend_q <= kill_pend_d;
            if (enter_req) req_pc_q <= pc_d;
            if (load_inst) begin
                inst_o      <= pick_inst(mem_rdata_i, req_pc_q[2]);
                inst_addr_o <= req_pc_q;
            end
        end
    end

    assign mem_req_o    = (state_q == REQ);
    assign mem_addr_o   = req_pc_q & DWORD_ALIGN_MASK;
    assign inst_valid_o = (state_q == HOLD) && !jump_en_i;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_inc        (inst_valid_o && id_ready_i),
        .stall_inc        (inst_valid_o && !id_ready_i),
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );
`endif

endmodule
